// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and entry type for the instruction-fetch front end.
package fetch_pkg;
  localparam int DEF_XLEN = 64;
  localparam int DEF_ILEN = 32;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x W synchronous FIFO with flush (priority over push/pop) and occupancy count.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    rd_d = rd_q;
    wr_d = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d = '0;
      wr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      mem_q <= mem_d;
    end
  end
  // The issuer's credit accounting must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) assert (count_q != FULL) else $error("sync_fifo push while full");
  end
  assign head = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues in-order imem requests with credit-based flow
// control and buffers returned instructions with their PCs for the IF/ID stage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN = DEF_XLEN,
  parameter int ILEN = DEF_ILEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_cnt_q, drop_cnt_d, count;
  logic req_fire, push, pop;
  logic [XLEN+ILEN-1:0] head;
  always_comb begin
    imem_req_valid = reset && !redirect_valid && ({1'b0, count} + {1'b0, inflight_q} < CAP);
    imem_req_addr = fetch_pc_q;
    inst_valid = (count != '0) && !redirect_valid;
    {inst_pc, inst_data} = head;
    req_fire = imem_req_valid && imem_req_ready;
    push = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    pop = inst_valid && inst_ready;
    // No request fires during a redirect, so this also yields inflight - rsp on redirect.
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d = redirect_valid ? inflight_q - CW'(imem_rsp_valid)
                                : drop_cnt_q - CW'(imem_rsp_valid && drop_cnt_q != '0);
    fetch_pc_d = redirect_valid ? redirect_pc : req_fire ? fetch_pc_q + STEP : fetch_pc_q;
    rsp_pc_d = redirect_valid ? redirect_pc : push ? rsp_pc_q + STEP : rsp_pc_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  sync_fifo #(
    .DEPTH(DEPTH),
    .W(XLEN + ILEN),
    .INIT({RESET_PC, ILEN'(0)})
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(redirect_valid),
    .push(push),
    .push_data({rsp_pc_q, imem_rsp_data}),
    .pop(pop),
    .head(head),
    .count(count)
  );
endmodule
